debounce_multi: RTL

Parametrised multi-channel switch/button debouncer: CH independent inputs, each synchronised, filtered by a per-channel four-state FSMD with a down-counter, and reported as a clean level plus one-cycle rising and falling ticks. Sits between raw board I/O (switches, push-buttons) and user logic, replacing single-channel debounce instances. A shared count-enable input lets one prescaler stretch the filter window without widening every counter.

---
 rtl/debounce_pkg.sv | 17 +
 rtl/debounce_multi_if.sv | 23 ++
 rtl/debounce_chan.sv | 100 ++++++++++
 rtl/debounce_multi.sv | 55 +++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared definitions for the multi-channel debouncer: FSM state encoding and
// the filter window length helper.
package debounce_pkg;

  typedef enum logic [1:0] {
    ZERO  = 2'b00,
    WAIT0 = 2'b01,
    ONE   = 2'b10,
    WAIT1 = 2'b11
  } db_state_e;

  // Number of counted cycles a new level must persist before it is accepted.
  function automatic int window_len(input int n);
    return (1 << n) - 1;
  endfunction

endpackage

// File: rtl/debounce_multi_if.sv
// Bundle of raw switch inputs, shared count enable and debounced outputs.
interface debounce_multi_if #(
  parameter int CH = 4
);

  logic [CH-1:0] sw;
  logic          cnt_en;
  logic [CH-1:0] db_level;
  logic [CH-1:0] rise_tick;
  logic [CH-1:0] fall_tick;
  logic          busy;

  modport master (
    output sw, cnt_en,
    input  db_level, rise_tick, fall_tick, busy
  );

  modport slave (
    input  sw, cnt_en,
    output db_level, rise_tick, fall_tick, busy
  );

endinterface

// File: rtl/debounce_chan.sv
// One debounce channel: multi-flop synchroniser followed by a four-state
// FSMD whose down-counter times the stability window.
module debounce_chan
  import debounce_pkg::*;
#(
  parameter int N           = 21,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sw,
  input  logic cnt_en,
  output logic db_level,
  output logic rise_tick,
  output logic fall_tick,
  output logic waiting
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  db_state_e              state_q, state_d;
  logic [N-1:0]           cnt_q, cnt_d, cnt_dec;
  logic                   level_q, level_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   s;

  assign s       = sync_q[SYNC_STAGES-1];
  assign cnt_dec = cnt_q - N'(1);
  assign sync_d  = {sync_q[SYNC_STAGES-2:0], sw};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      ZERO: begin
        if (s) begin
          cnt_d   = '1;
          state_d = WAIT1;
        end
      end
      WAIT1: begin
        if (!s) begin
          state_d = ZERO;
        end else if (cnt_en) begin
          cnt_d = cnt_dec;
          if (cnt_dec == '0) begin
            state_d = ONE;
            rise_d  = 1'b1;
          end
        end
      end
      ONE: begin
        if (!s) begin
          cnt_d   = '1;
          state_d = WAIT0;
        end
      end
      WAIT0: begin
        if (s) begin
          state_d = ONE;
        end else if (cnt_en) begin
          cnt_d = cnt_dec;
          if (cnt_dec == '0) begin
            state_d = ZERO;
            fall_d  = 1'b1;
          end
        end
      end
      default: state_d = ZERO;
    endcase
    // Outputs follow the next state so they land on the same edge as the state.
    level_d = (state_d == ONE) || (state_d == WAIT0);
    waiting = (state_d == WAIT1) || (state_d == WAIT0);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_q  <= '0;
      state_q <= ZERO;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign db_level  = level_q;
  assign rise_tick = rise_q;
  assign fall_tick = fall_q;

endmodule

// File: rtl/debounce_multi.sv
// CH independent debounce channels sharing one count enable, plus a
// registered busy flag covering every channel that is mid-window.
module debounce_multi
  import debounce_pkg::*;
#(
  parameter int CH          = 4,
  parameter int N           = 21,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  debounce_multi_if.slave  bus
);

  logic [CH-1:0] level_vec;
  logic [CH-1:0] rise_vec;
  logic [CH-1:0] fall_vec;
  logic [CH-1:0] waiting_vec;
  logic          busy_q, busy_d;

  for (genvar i = 0; i < CH; i++) begin : g_chan
    debounce_chan #(
      .N           (N),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_chan (
      .clk       (clk),
      .reset_n   (reset_n),
      .sw        (bus.sw[i]),
      .cnt_en    (bus.cnt_en),
      .db_level  (level_vec[i]),
      .rise_tick (rise_vec[i]),
      .fall_tick (fall_vec[i]),
      .waiting   (waiting_vec[i])
    );
  end

  // waiting reflects each channel's next state, so busy lines up with db_level.
  always_comb begin
    busy_d = |waiting_vec;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      busy_q <= 1'b0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign bus.db_level  = level_vec;
  assign bus.rise_tick = rise_vec;
  assign bus.fall_tick = fall_vec;
  assign bus.busy      = busy_q;

endmodule
